mem_port_arbiter: RTL and testbench

//  Shares the single synchronous RAM (one read port, one write port) between NUM_REQ requesters
//  (req 0 = exec_unit, req 1 = program loader/debug port). Round-robin arbitration with bounded bus lock;
//  one transaction in flight at a time. Sits between requesters and RAM; RAM reads are 1-cycle registered.

---
 rtl/constants_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// Shared constants and types for the memory port arbiter.
//   MEMORY_ADDRESS_BITS / MEMORY_DATA_BITS : RAM geometry
//   ArbState                               : arbiter FSM encoding
package constants_pkg;

    localparam int unsigned MEMORY_ADDRESS_BITS = 8;
    localparam int unsigned MEMORY_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } ArbState;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans req starting at index start and
// wrapping, first asserted index wins.
//   req      in  N   request vector
//   start    in  IW  index searched first
//   grant_c  out N   one-hot winner (0 when no request)
//   idx_c    out IW  winner index
//   any_c    out 1   at least one request present
module rr_priority_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    int unsigned pos;

    // Rotating first-one search.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        pos     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(start) + k) % N;
            if (!any_c && req[pos]) begin
                any_c   = 1'b1;
                grant_c = N'(1) << pos;
                idx_c   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM (1 read + 1 write port) between NUM_REQ
// requesters with round-robin arbitration and a bounded priority lock.
// One transaction in flight; RAM reads have one cycle of latency.
//   clk, reset_n                       clock, async active-low reset
//   req / req_we / req_lock            per-requester request, direction, lock
//   req_addr / req_wdata               packed per-requester address / data
//   gnt, rvalid                        one-hot accept / read-response pulses
//   rdata                              shared read data, held between rvalids
//   ram_rd_en/addr, ram_rd_data        RAM read port
//   ram_wr_en/addr/data                RAM write port
module mem_port_arbiter
    import constants_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ADDR_BITS = MEMORY_ADDRESS_BITS,
    parameter int unsigned DATA_BITS = MEMORY_DATA_BITS,
    parameter int unsigned MAX_LOCK  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_BITS-1:0]           rdata,
    output logic                           ram_rd_en,
    output logic [ADDR_BITS-1:0]           ram_rd_addr,
    input  logic [DATA_BITS-1:0]           ram_rd_data,
    output logic                           ram_wr_en,
    output logic [ADDR_BITS-1:0]           ram_wr_addr,
    output logic [DATA_BITS-1:0]           ram_wr_data
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    ArbState                 state_q, state_d;
    logic [IW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    keep_q, keep_d;
    logic                    we_q, we_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
    logic [DATA_BITS-1:0]    rdata_q, rdata_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0]    rd_addr_q, rd_addr_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]    wr_data_q, wr_data_d;

    logic                    keep_hit_c;
    logic [IW-1:0]           next_ptr_c;
    logic [IW-1:0]           start_c;
    logic                    lock_ok_c;
    logic [NUM_REQ-1:0]      pick_grant_c;
    logic [IW-1:0]           pick_idx_c;
    logic                    pick_any_c;
    int unsigned             sel_c;

    // Search start: the locked winner keeps priority while it still requests.
    assign keep_hit_c = keep_q && req[last_q];
    assign next_ptr_c = (last_q == IW'(NUM_REQ - 1)) ? '0 : last_q + IW'(1);
    assign start_c    = keep_hit_c ? last_q : next_ptr_c;
    assign sel_c      = 32'(pick_idx_c);

    // Lock is granted only while the run stays below MAX_LOCK grants.
    assign lock_ok_c  = req_lock[last_q] && ((32'(cnt_q) + 32'd1) < MAX_LOCK);

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req     (req),
        .start   (start_c),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            last_q    <= IW'(NUM_REQ - 1);
            cnt_q     <= '0;
            keep_q    <= 1'b0;
            we_q      <= 1'b0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            keep_q    <= keep_d;
            we_q      <= we_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next state; output values are computed one cycle ahead and registered.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        keep_d    = keep_q;
        we_d      = we_q;
        gnt_d     = '0;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;

        unique case (state_q)
            ARB_IDLE: begin
                // A locked winner that stopped requesting forfeits its run.
                if (keep_q && !req[last_q]) begin
                    keep_d = 1'b0;
                    cnt_d  = '0;
                end
                if (pick_any_c) begin
                    state_d = ARB_ISSUE;
                    last_d  = pick_idx_c;
                    keep_d  = 1'b0;
                    we_d    = req_we[pick_idx_c];
                    gnt_d   = pick_grant_c;
                    if (req_we[pick_idx_c]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = req_addr[sel_c*ADDR_BITS +: ADDR_BITS];
                        wr_data_d = req_wdata[sel_c*DATA_BITS +: DATA_BITS];
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = req_addr[sel_c*ADDR_BITS +: ADDR_BITS];
                    end
                end
            end
            ARB_ISSUE: begin
                if (lock_ok_c) begin
                    keep_d = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    keep_d = 1'b0;
                    cnt_d  = '0;
                end
                state_d = we_q ? ARB_IDLE : ARB_WAIT;
            end
            ARB_WAIT: begin
                rvalid_d = NUM_REQ'(1) << last_q;
                rdata_d  = ram_rd_data;
                state_d  = ARB_RESP;
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign ram_rd_en   = rd_en_q;
    assign ram_rd_addr = rd_addr_q;
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions,
// hand sequences for reset abort, fairness, lock bound and dropped requests.
// Read responses are checked through an expected-response queue.
module tb_mem_port_arbiter;
    import constants_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AB = MEMORY_ADDRESS_BITS;
    localparam int unsigned DB = MEMORY_DATA_BITS;
    localparam int unsigned ML = 4;

    logic                clk;
    logic                reset_n;
    logic [NR-1:0]       req;
    logic [NR-1:0]       req_we;
    logic [NR-1:0]       req_lock;
    logic [NR*AB-1:0]    req_addr;
    logic [NR*DB-1:0]    req_wdata;
    logic [NR-1:0]       gnt;
    logic [NR-1:0]       rvalid;
    logic [DB-1:0]       rdata;
    logic                ram_rd_en;
    logic [AB-1:0]       ram_rd_addr;
    logic [DB-1:0]       ram_rd_data;
    logic                ram_wr_en;
    logic [AB-1:0]       ram_wr_addr;
    logic [DB-1:0]       ram_wr_data;

    mem_port_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .MAX_LOCK  (ML)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_we      (req_we),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with registered read.
    logic [DB-1:0] mem [0:(1<<AB)-1];
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    typedef struct {
        int          id;
        logic [DB-1:0] data;
    } exp_t;

    typedef struct {
        int            id;
        bit            we;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata;
        logic [DB-1:0] exp_rdata;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every rvalid.
    always @(negedge clk) begin
        if (reset_n) begin
            if ($countones(gnt) > 1 || $countones(rvalid) > 1 || (ram_rd_en && ram_wr_en)) begin
                n_cmp++;
                n_fail++;
                $display("FAIL exclusive_outputs: gnt=%b rvalid=%b rd_en=%b wr_en=%b", gnt, rvalid, ram_rd_en, ram_wr_en);
            end
            if (rvalid != '0) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid: actual=%b required=none", rvalid);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rvalid_owner", 32'(rvalid), 32'(1) << mon_e.id);
                    check("rdata", 32'(rdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic drive(input int id, input bit we, input logic [AB-1:0] addr,
                         input logic [DB-1:0] wdata, input bit lock);
        req[id]               = 1'b1;
        req_we[id]            = we;
        req_lock[id]          = lock;
        req_addr[id*AB +: AB] = addr;
        req_wdata[id*DB +: DB] = wdata;
    endtask

    task automatic release_req(input int id);
        req[id]      = 1'b0;
        req_lock[id] = 1'b0;
    endtask

    task automatic push_exp(input int id, input logic [DB-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0; req_we = '0; req_lock = '0;
        #1;
        check("rst_gnt",     32'(gnt), 32'd0);
        check("rst_rvalid",  32'(rvalid), 32'd0);
        check("rst_enables", {30'd0, ram_rd_en, ram_wr_en}, 32'd0);
        check("rst_rdata",   32'(rdata), 32'd0);
        check("rst_addrs",   {16'd0, ram_rd_addr, ram_wr_addr}, 32'd0);
        check("rst_wdata",   32'(ram_wr_data), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One isolated transaction with cycle-exact checks.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.id, v.we, v.addr, v.wdata, 1'b0);
        if (!v.we) push_exp(v.id, v.exp_rdata);
        @(negedge clk);
        check("vec_gnt",   32'(gnt), 32'(1) << v.id);
        check("vec_rd_en", 32'(ram_rd_en), 32'(!v.we));
        check("vec_wr_en", 32'(ram_wr_en), 32'(v.we));
        if (v.we) begin
            check("vec_wr_addr", 32'(ram_wr_addr), 32'(v.addr));
            check("vec_wr_data", 32'(ram_wr_data), 32'(v.wdata));
        end else begin
            check("vec_rd_addr", 32'(ram_rd_addr), 32'(v.addr));
            check("vec_wr_data_idle", 32'(ram_wr_data), 32'd0);
        end
        release_req(v.id);
        if (!v.we) begin
            @(negedge clk);
            check("vec_rvalid_early", 32'(rvalid), 32'd0);
            @(negedge clk);
            check("vec_rvalid_cycle3", 32'(rvalid), 32'(1) << v.id);
        end
    endtask

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                idx = gnt[1] ? 1 : 0;
                break;
            end
        end
    endtask

    vec_t vecs[9];
    int   exp3[6];
    int   exp4[10];
    int   got;
    logic seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;

        vecs[0] = '{1, 1'b1, 8'h20, 8'h3C, 8'h00};
        vecs[1] = '{0, 1'b0, 8'h20, 8'h00, 8'h3C};
        vecs[2] = '{0, 1'b1, 8'h10, 8'hA5, 8'h00};
        vecs[3] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[4] = '{1, 1'b1, 8'hFF, 8'h81, 8'h00};
        vecs[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'h81};
        vecs[6] = '{0, 1'b1, 8'h00, 8'h7E, 8'h00};
        vecs[7] = '{1, 1'b0, 8'h00, 8'h00, 8'h7E};
        vecs[8] = '{0, 1'b0, 8'h20, 8'h00, 8'h3C};
        exp3 = '{0, 1, 0, 1, 0, 1};
        exp4 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        do_reset();

        // Single transactions, including write-then-read to the same address.
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset while a read is in WAIT: aborted, requester 0 first afterwards.
        @(negedge clk);
        drive(0, 1'b0, 8'h10, 8'h00, 1'b0);
        @(negedge clk);
        check("t1_gnt", 32'(gnt), 32'd1);
        release_req(0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t1_rst_rvalid", 32'(rvalid), 32'd0);
        check("t1_rst_enables", {30'd0, ram_rd_en, ram_wr_en}, 32'd0);
        check("t1_rst_rdata", 32'(rdata), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rvalid != '0) seen = 1'b1;
        end
        check("t1_no_rvalid", 32'(seen), 32'd0);
        reset_n = 1'b1;
        drive(0, 1'b0, 8'h10, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h20, 8'h00, 1'b0);
        push_exp(0, 8'hA5);
        push_exp(1, 8'h3C);
        @(negedge clk);
        check("t1_first_gnt", 32'(gnt), 32'd1);
        release_req(0);
        wait_gnt(got);
        check("t1_second_gnt", 32'(got), 32'd1);
        release_req(1);
        repeat (4) @(negedge clk);

        // Both requesters continuous, no lock: strict alternation.
        do_reset();
        @(negedge clk);
        drive(0, 1'b1, 8'h30, 8'h11, 1'b0);
        drive(1, 1'b1, 8'h31, 8'h22, 1'b0);
        for (int k = 0; k < 6; k++) begin
            wait_gnt(got);
            check($sformatf("t3_grant%0d", k), 32'(got), 32'(exp3[k]));
        end
        release_req(0);
        release_req(1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (gnt != '0 || ram_wr_en || ram_rd_en) seen = 1'b1;
        end
        check("t3_quiet_after_drop", 32'(seen), 32'd0);

        // Requester 0 locking: at most MAX_LOCK grants in a row.
        do_reset();
        @(negedge clk);
        drive(0, 1'b1, 8'h40, 8'h33, 1'b1);
        drive(1, 1'b1, 8'h41, 8'h44, 1'b0);
        for (int k = 0; k < 10; k++) begin
            wait_gnt(got);
            check($sformatf("t4_grant%0d", k), 32'(got), 32'(exp4[k]));
        end
        release_req(0);
        release_req(1);
        repeat (3) @(negedge clk);

        // Request withdrawn before being sampled: nothing happens.
        @(negedge clk);
        drive(0, 1'b0, 8'h10, 8'h00, 1'b0);
        #2;
        release_req(0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (gnt != '0 || ram_rd_en || ram_wr_en) seen = 1'b1;
        end
        check("t6_no_activity", 32'(seen), 32'd0);
        run_vec(vecs[3]);

        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
